// File: rtl/charlie_pkg.sv
// Shared definitions for the Charlie sprite motion controller.
//   state_t      : motion sequencer states
//   MULTIPLIER   : fixed-point scale (1/64 pixel), FRAC_BITS its log2
//   SCREEN_*_MAX : last visible pixel column/row, SPRITE_W sprite width
//   to_fixed()   : pixel -> fixed-point helper
package charlie_pkg;

  typedef enum logic [2:0] {
    GROUND = 3'd0,
    RISE   = 3'd1,
    FALL   = 3'd2,
    HIT    = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam int MULTIPLIER   = 64;
  localparam int FRAC_BITS    = 6;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  localparam int SPRITE_W     = 32;

  function automatic logic signed [31:0] to_fixed(input int px);
    return 32'(px * MULTIPLIER);
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one-clk pulse on the clk where `in` is high and
// was low on the previous clk.
//   clk, resetN : clock, async active-low reset
//   in          : level input
//   pulse       : in & ~in(previous clk)
module edge_detect_rise (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic in_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) in_d <= 1'b0;
    else         in_d <= in;
  end

  assign pulse = in & ~in_d;

endmodule

// File: rtl/charlie_motion_ctrl.sv
// Player sprite (Charlie) motion controller: walk, jump rise/fall/land,
// hit freeze with respawn, game over. Position kept in 1/64-pixel fixed point.
//   clk, resetN           : clock, async active-low reset
//   startOfFrame          : one-clk frame tick, gates all motion updates
//   key_jump/left/right   : keyboard levels
//   collision             : obstacle hit, level (may last several clks)
//   topLeftX/topLeftY     : sprite top-left in pixels
//   airborne, hit         : in RISE/FALL, in HIT
//   lives_left, game_over : remaining lives, in OVER
//
// state  | meaning
// GROUND | standing on ground, walking, waiting for a jump request
// RISE   | moving up, speed decaying by gravity
// FALL   | moving down until the ground line is reached
// HIT    | frozen for HIT_FRAMES frames after a collision
// OVER   | no lives left, frozen until reset
module charlie_motion_ctrl
  import charlie_pkg::*;
#(
  parameter int INITIAL_X  = 64,
  parameter int GROUND_Y   = 400,
  parameter int X_MAX      = SCREEN_X_MAX - SPRITE_W,
  parameter int X_SPEED    = 128,
  parameter int JUMP_SPEED = 512,
  parameter int GRAVITY    = 32,
  parameter int HIT_FRAMES = 60,
  parameter int LIVES      = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        key_jump,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        airborne,
  output logic        hit,
  output logic [1:0]  lives_left,
  output logic        game_over
);

  localparam logic signed [31:0] X_INIT   = to_fixed(INITIAL_X);
  localparam logic signed [31:0] Y_GROUND = to_fixed(GROUND_Y);
  localparam logic signed [31:0] X_LIM    = to_fixed(X_MAX);
  localparam logic signed [31:0] X_STEP   = 32'(X_SPEED);
  localparam logic signed [31:0] V_JUMP   = 32'(-JUMP_SPEED);
  localparam logic signed [31:0] V_GRAV   = 32'(GRAVITY);
  localparam logic [6:0]         HIT_LOAD = 7'(HIT_FRAMES);
  localparam logic [1:0]         LIVES_0  = 2'(LIVES);

  state_t state, state_nx;
  logic signed [31:0] pos_x, pos_x_nx, pos_y, pos_y_nx, y_speed, y_speed_nx;
  logic signed [31:0] x_cand, x_clamped, y_cand, y_speed_g;
  logic [1:0] lives, lives_nx;
  logic [6:0] hit_cnt, hit_cnt_nx;
  logic jump_pend, jump_clr, jump_edge, in_motion;

  edge_detect_rise u_jump_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (key_jump),
    .pulse  (jump_edge)
  );

  assign in_motion = (state == GROUND) || (state == RISE) || (state == FALL);
  assign y_cand    = pos_y + y_speed;
  assign y_speed_g = y_speed + V_GRAV;

  // Opposing keys cancel; result clamped to the legal X range.
  always_comb begin
    x_cand = pos_x;
    if (key_right && !key_left)      x_cand = pos_x + X_STEP;
    else if (key_left && !key_right) x_cand = pos_x - X_STEP;
    if (x_cand < 0)          x_clamped = '0;
    else if (x_cand > X_LIM) x_clamped = X_LIM;
    else                     x_clamped = x_cand;
  end

  always_comb begin
    state_nx   = state;
    pos_x_nx   = pos_x;
    pos_y_nx   = pos_y;
    y_speed_nx = y_speed;
    lives_nx   = lives;
    hit_cnt_nx = hit_cnt;
    jump_clr   = 1'b0;
    case (state)
      GROUND, RISE, FALL: begin
        // Collision is checked first so it beats a jump or landing on the same clk.
        if (collision) begin
          state_nx   = HIT;
          lives_nx   = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
          hit_cnt_nx = HIT_LOAD;
          jump_clr   = 1'b1;
        end else if (startOfFrame) begin
          pos_x_nx = x_clamped;
          if (state == GROUND) begin
            if (jump_pend) begin
              y_speed_nx = V_JUMP;
              jump_clr   = 1'b1;
              state_nx   = RISE;
            end
          end else if (state == RISE) begin
            pos_y_nx   = y_cand;
            y_speed_nx = y_speed_g;
            if (!y_speed_g[31]) state_nx = FALL;
          end else begin
            if (y_cand >= Y_GROUND) begin
              pos_y_nx   = Y_GROUND;
              y_speed_nx = '0;
              state_nx   = GROUND;
            end else begin
              pos_y_nx   = y_cand;
              y_speed_nx = y_speed_g;
            end
          end
        end
      end
      HIT: begin
        if (startOfFrame) begin
          if (hit_cnt == 7'd1) begin
            hit_cnt_nx = '0;
            if (lives != 2'd0) begin
              pos_x_nx   = X_INIT;
              pos_y_nx   = Y_GROUND;
              y_speed_nx = '0;
              state_nx   = GROUND;
            end else begin
              state_nx = OVER;
              jump_clr = 1'b1;
            end
          end else begin
            hit_cnt_nx = hit_cnt - 7'd1;
          end
        end
      end
      OVER: state_nx = OVER;
      default: state_nx = GROUND;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= GROUND;
      pos_x     <= X_INIT;
      pos_y     <= Y_GROUND;
      y_speed   <= '0;
      lives     <= LIVES_0;
      hit_cnt   <= '0;
      jump_pend <= 1'b0;
    end else begin
      state   <= state_nx;
      pos_x   <= pos_x_nx;
      pos_y   <= pos_y_nx;
      y_speed <= y_speed_nx;
      lives   <= lives_nx;
      hit_cnt <= hit_cnt_nx;
      // Jump presses are only remembered while Charlie can move.
      if (jump_clr)                    jump_pend <= 1'b0;
      else if (jump_edge && in_motion) jump_pend <= 1'b1;
    end
  end

  assign topLeftX   = 11'(pos_x >>> FRAC_BITS);
  assign topLeftY   = 11'(pos_y >>> FRAC_BITS);
  assign airborne   = (state == RISE) || (state == FALL);
  assign hit        = (state == HIT);
  assign game_over  = (state == OVER);
  assign lives_left = lives;

endmodule

// File: tb/tb_charlie_motion_ctrl.sv
// Self-checking bench for charlie_motion_ctrl: directed sequences, a walk
// table, and randomized episodes against a frame-level behavioural model.
module tb_charlie_motion_ctrl;

  localparam int INITIAL_X  = 64;
  localparam int GROUND_Y   = 400;
  localparam int X_MAX      = 607;
  localparam int X_SPEED    = 128;
  localparam int JUMP_SPEED = 512;
  localparam int GRAVITY    = 32;
  localparam int HIT_FRAMES = 60;
  localparam int LIVES      = 3;

  localparam int M_GND = 0, M_RISE = 1, M_FALL = 2, M_HIT = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, key_jump = 1'b0, key_left = 1'b0, key_right = 1'b0, collision = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic airborne, hit, game_over;
  logic [1:0] lives_left;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  charlie_motion_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .key_jump     (key_jump),
    .key_left     (key_left),
    .key_right    (key_right),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .airborne     (airborne),
    .hit          (hit),
    .lives_left   (lives_left),
    .game_over    (game_over)
  );

  // Behavioural model state
  int m_mode, m_x, m_y, m_vy, m_lives, m_hcnt;
  bit m_pend, m_kprev;

  typedef struct {
    bit kl;
    bit kr;
    int frames;
    int exp_x;
  } walk_vec_t;
  walk_vec_t wv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    startOfFrame = 0; key_jump = 0; key_left = 0; key_right = 0; collision = 0;
    resetN = 1'b0;
    #2;
    check("rst_x", 32'(topLeftX), 32'(INITIAL_X));
    check("rst_y", 32'(topLeftY), 32'(GROUND_Y));
    check("rst_lives", 32'(lives_left), 32'(LIVES));
    check("rst_air", 32'(airborne), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_over", 32'(game_over), 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = M_GND; m_x = INITIAL_X * 64; m_y = GROUND_Y * 64; m_vy = 0;
    m_lives = LIVES; m_hcnt = 0; m_pend = 0; m_kprev = 0;
  endtask

  // One clk of the model, using the inputs present at that clock edge.
  task automatic model_step(input bit sof, input bit kj, input bit kl, input bit kr, input bit col);
    bit rise_edge;
    bit clr;
    int nx;
    rise_edge = kj && !m_kprev;
    clr = 0;
    m_kprev = kj;
    if (m_mode == M_GND || m_mode == M_RISE || m_mode == M_FALL) begin
      if (col) begin
        m_mode = M_HIT;
        if (m_lives > 0) m_lives = m_lives - 1;
        m_hcnt = HIT_FRAMES;
        clr = 1;
      end else if (sof) begin
        nx = m_x + ((kr && !kl) ? X_SPEED : 0) - ((kl && !kr) ? X_SPEED : 0);
        if (nx < 0) nx = 0;
        if (nx > X_MAX * 64) nx = X_MAX * 64;
        m_x = nx;
        if (m_mode == M_GND) begin
          if (m_pend) begin
            m_vy = -JUMP_SPEED;
            clr = 1;
            m_mode = M_RISE;
          end
        end else if (m_mode == M_RISE) begin
          m_y = m_y + m_vy;
          m_vy = m_vy + GRAVITY;
          if (m_vy >= 0) m_mode = M_FALL;
        end else begin
          if (m_y + m_vy >= GROUND_Y * 64) begin
            m_y = GROUND_Y * 64;
            m_vy = 0;
            m_mode = M_GND;
          end else begin
            m_y = m_y + m_vy;
            m_vy = m_vy + GRAVITY;
          end
        end
      end
      if (clr) m_pend = 0;
      else if (rise_edge) m_pend = 1;
    end else if (m_mode == M_HIT && sof) begin
      if (m_hcnt == 1) begin
        m_hcnt = 0;
        if (m_lives > 0) begin
          m_x = INITIAL_X * 64; m_y = GROUND_Y * 64; m_vy = 0; m_mode = M_GND;
        end else begin
          m_mode = M_OVER;
        end
      end else begin
        m_hcnt = m_hcnt - 1;
      end
    end
  endtask

  initial begin
    int n;
    int col_hold;

    wv[0] = '{0, 1, 10, 84};
    wv[1] = '{1, 0, 5, 74};
    wv[2] = '{1, 1, 3, 74};
    wv[3] = '{0, 0, 2, 74};
    wv[4] = '{1, 0, 40, 0};
    wv[5] = '{0, 1, 310, 607};
    wv[6] = '{1, 1, 5, 607};
    wv[7] = '{1, 0, 1, 605};

    // Reset and idle
    tick();
    do_reset();
    frames(10);
    check("idle_x", 32'(topLeftX), 64);
    check("idle_y", 32'(topLeftY), 400);
    check("idle_lives", 32'(lives_left), 3);
    check("idle_air", 32'(airborne), 0);

    // Jump arc: 16 rise frames to apex 332, lands on the 17th fall frame
    key_jump = 1; tick(); key_jump = 0;
    frame();
    check("jump_frame_air", 32'(airborne), 1);
    check("jump_frame_y", 32'(topLeftY), 400);
    frames(16);
    check("apex_y", 32'(topLeftY), 332);
    check("apex_air", 32'(airborne), 1);
    n = 0;
    while (airborne && n < 40) begin
      frame();
      n++;
    end
    check("fall_frames", n, 17);
    check("land_total_frames", n + 16, 33);
    check("land_y", 32'(topLeftY), 400);
    check("land_x", 32'(topLeftX), 64);

    // Walk table
    for (int i = 0; i < 8; i++) begin
      key_left = wv[i].kl;
      key_right = wv[i].kr;
      frames(wv[i].frames);
      check($sformatf("walk%0d_x", i), 32'(topLeftX), 32'(wv[i].exp_x));
      check($sformatf("walk%0d_y", i), 32'(topLeftY), 400);
    end
    key_left = 0; key_right = 0;

    // Hit mid-rise at Y=350, keys ignored during freeze, then respawn
    do_reset();
    key_jump = 1; tick(); key_jump = 0;
    key_right = 1;
    frame();
    frames(8);
    check("rise8_y", 32'(topLeftY), 350);
    check("rise8_x", 32'(topLeftX), 82);
    collision = 1;
    tick();
    check("hit1_hit", 32'(hit), 1);
    check("hit1_lives", 32'(lives_left), 2);
    check("hit1_air", 32'(airborne), 0);
    tick(); tick();
    collision = 0;
    for (int f = 0; f < 59; f++) begin
      frame();
      check("hit1_frozen_y", 32'(topLeftY), 350);
      check("hit1_frozen_x", 32'(topLeftX), 82);
      check("hit1_still_hit", 32'(hit), 1);
    end
    key_right = 0;
    frame();
    check("respawn1_hit", 32'(hit), 0);
    check("respawn1_x", 32'(topLeftX), 64);
    check("respawn1_y", 32'(topLeftY), 400);
    check("respawn1_air", 32'(airborne), 0);
    check("respawn1_lives", 32'(lives_left), 2);

    // Collision and jump edge on the same frame clk: hit wins, jump dropped
    key_jump = 1; collision = 1; startOfFrame = 1;
    tick();
    startOfFrame = 0; collision = 0;
    check("hit2_hit", 32'(hit), 1);
    check("hit2_lives", 32'(lives_left), 1);
    check("hit2_y", 32'(topLeftY), 400);
    tick();
    key_jump = 0;
    frames(59);
    check("hit2_still_hit", 32'(hit), 1);
    frame();
    check("respawn2_hit", 32'(hit), 0);
    frames(5);
    check("nojump_air", 32'(airborne), 0);
    check("nojump_y", 32'(topLeftY), 400);
    check("nojump_x", 32'(topLeftX), 64);

    // Third hit -> game over, frozen at hit position
    key_right = 1; frames(10); key_right = 0;
    check("pre3_x", 32'(topLeftX), 84);
    collision = 1; tick(); collision = 0;
    check("hit3_hit", 32'(hit), 1);
    check("hit3_lives", 32'(lives_left), 0);
    frames(59);
    check("hit3_not_over_yet", 32'(game_over), 0);
    frame();
    check("over", 32'(game_over), 1);
    check("over_hit", 32'(hit), 0);
    check("over_lives", 32'(lives_left), 0);
    check("over_x", 32'(topLeftX), 84);
    check("over_y", 32'(topLeftY), 400);
    key_jump = 1; key_left = 1; collision = 1;
    frames(20);
    key_jump = 0; key_left = 0; collision = 0;
    key_right = 1; frames(5); key_right = 0;
    check("over_hold", 32'(game_over), 1);
    check("over_hold_lives", 32'(lives_left), 0);
    check("over_hold_x", 32'(topLeftX), 84);
    check("over_hold_y", 32'(topLeftY), 400);
    check("over_hold_air", 32'(airborne), 0);
    do_reset();
    frame();
    check("post_over_lives", 32'(lives_left), 3);
    check("post_over_flag", 32'(game_over), 0);

    // Randomized episodes against the model; each starts with a reset mid-activity
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      model_reset();
      col_hold = 0;
      for (int c = 0; c < 1500; c++) begin
        startOfFrame = (c % 3 == 0);
        if ($urandom_range(0, 19) == 0) key_left = ~key_left;
        if ($urandom_range(0, 19) == 0) key_right = ~key_right;
        if ($urandom_range(0, 5) == 0) key_jump = ~key_jump;
        if (col_hold == 0 && $urandom_range(0, 399) == 0) col_hold = $urandom_range(1, 3);
        collision = (col_hold > 0);
        if (col_hold > 0) col_hold--;
        model_step(startOfFrame, key_jump, key_left, key_right, collision);
        tick();
        check("rnd_x", 32'(topLeftX), 32'(m_x / 64));
        check("rnd_y", 32'(topLeftY), 32'(m_y / 64));
        check("rnd_air", 32'(airborne), 32'(m_mode == M_RISE || m_mode == M_FALL));
        check("rnd_hit", 32'(hit), 32'(m_mode == M_HIT));
        check("rnd_over", 32'(game_over), 32'(m_mode == M_OVER));
        check("rnd_lives", 32'(lives_left), 32'(m_lives));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/charlie_motion_ctrl.md
Name: charlie_motion_ctrl

Overview:
Frame-rate controller for the player sprite (Charlie). It turns keyboard commands and collision pulses into a sequenced motion: walk, jump rise, fall and land, then hit freeze with respawn or game over. It owns the sprite position in 1/64-pixel fixed point and outputs pixel top-left coordinates to the sprite drawer. It also reports life count and game state to the game-logic and score blocks.

Parameters:
INITIAL_X, 64, respawn X in pixels
GROUND_Y, 400, ground-level top-left Y in pixels
X_MAX, 607, rightmost legal top-left X in pixels (639 minus sprite width 32)
X_SPEED, 128, horizontal step per frame, fixed point (2 px)
JUMP_SPEED, 512, initial upward speed magnitude, fixed point (8 px/frame)
GRAVITY, 32, speed increment per frame, fixed point
HIT_FRAMES, 60, frames frozen after a hit
LIVES, 3, lives at reset

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame
key_jump  in  1  jump key level
key_left  in  1  left key level
key_right  in  1  right key level
collision  in  1  player-vs-obstacle hit, may last several clks
topLeftX  out  11  sprite X in pixels (posX/64)
topLeftY  out  11  sprite Y in pixels (posY/64)
airborne  out  1  high in RISE or FALL
hit  out  1  high in HIT
lives_left  out  2  remaining lives
game_over  out  1  high in OVER

Behaviour:
- Reset: clk is the clock; resetN is the asynchronous, active-low reset. On reset: state GROUND, posX=INITIAL_X*64, posY=GROUND_Y*64, Yspeed=0, lives_left=LIVES, hit_cnt=0, jump_pend=0. Outputs at reset: topLeftX=64, topLeftY=400, airborne=0, hit=0, game_over=0.
- Arithmetic: 32-bit signed posX, posY and Yspeed, MULTIPLIER=64. Pixel outputs are an arithmetic shift right by 6, truncated to 11 bits.
- Jump request: a rising edge on key_jump (registered delay) sets jump_pend. jump_pend clears when a jump is consumed, or on entry to HIT or OVER.
- All motion updates happen only on clks where startOfFrame=1. Outputs are registered, so they change one clk after the pulse.
- Horizontal motion, in GROUND, RISE and FALL:
  - right only: posX += X_SPEED
  - left only: posX -= X_SPEED
  - both or neither: no change
  - result is clamped to [0, X_MAX*64]
- GROUND: on a frame with jump_pend=1, set Yspeed=-JUMP_SPEED, clear jump_pend, go to RISE. posY is not moved on that frame.
- RISE: each frame posY += Yspeed, then Yspeed += GRAVITY, both from old values. When the new Yspeed >= 0, go to FALL.
- FALL: each frame compute posY + Yspeed.
  - If it is >= GROUND_Y*64: posY=GROUND_Y*64, Yspeed=0, go to GROUND.
  - Otherwise: posY += Yspeed, Yspeed += GRAVITY.
- HIT entry: collision=1 in GROUND, RISE or FALL goes to HIT on the next clk, independent of startOfFrame.
  - Entry actions: lives_left -= 1, hit_cnt=HIT_FRAMES, position frozen.
  - Collision wins over a jump or landing in the same clk.
- HIT: collision is ignored. hit_cnt decrements per frame. At hit_cnt==1 on a frame:
  - lives_left>0: respawn to INITIAL_X/GROUND_Y with Yspeed=0, go to GROUND.
  - lives_left==0: go to OVER.
- OVER: all inputs ignored, position frozen. Only resetN exits OVER.
- lives_left saturates at 0 and never wraps.
- Reset mid-jump or mid-HIT returns immediately to the reset values.

Decomposition:
- Shared package (charlie_pkg):
  - state enum {GROUND, RISE, FALL, HIT, OVER}
  - MULTIPLIER=64
  - screen constants 639/479
- Optional sub-module edge_detect_rise (clk, resetN, in, pulse), reused for key_jump.
- Everything else stays in one FSM plus datapath module.

Test Plan:
1. Reset then idle 10 frames -> topLeftX=64, topLeftY=400, lives_left=3, airborne=0.
2. Pulse key_jump, run frames -> RISE for 16 frames, apex topLeftY=332; FALL lands exactly on frame 17 with topLeftY=400; airborne clears, GROUND reached 33 frames after the jump frame.
3. Hold key_right 300 frames from X=64 -> X rises 2 px/frame and clamps at 607. Then hold left and right together -> X stays 607.
4. Collision pulse mid-RISE at Y=350 -> hit=1 next clk, lives_left=2, Y frozen at 350 for 60 frames, then respawn at (64,400) in GROUND.
5. Collision and jump edge in the same frame -> HIT taken, jump_pend cleared, no jump after respawn.
6. Three hits -> after third freeze game_over=1, lives_left=0. Further collision or keys cause no change; resetN low restores (64,400) with lives_left=3.
